// File: rtl/bit_deframer_pkg.sv
// Shared types and constants for the serial bit deframer.
// Consumed by bit_deframer, its bit sampler and the bus interface.
package bit_deframer_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned FRAME_CNT_W   = 16;
  localparam int unsigned DEF_SYNC_W    = 16;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_WORD = 16'hEB90;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage : bit_deframer_pkg

// File: rtl/bit_deframer_if.sv
// Line-side inputs and byte-side outputs of bit_deframer.
// master = the deframer itself, slave = the line driver / byte consumer.
interface bit_deframer_if;
  import bit_deframer_pkg::*;

  logic                   signal;
  logic                   clk_rec;
  logic [BYTE_W-1:0]      byte_data;
  logic                   byte_valid;
  logic                   byte_first;
  logic                   locked;
  logic                   sync_err;
  logic                   pol_inv;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    input  signal,
    input  clk_rec,
    output byte_data,
    output byte_valid,
    output byte_first,
    output locked,
    output sync_err,
    output pol_inv,
    output frame_cnt
  );

  modport slave (
    output signal,
    output clk_rec,
    input  byte_data,
    input  byte_valid,
    input  byte_first,
    input  locked,
    input  sync_err,
    input  pol_inv,
    input  frame_cnt
  );

endinterface : bit_deframer_if

// File: rtl/bit_deframer_bit_sampler.sv
// Synchronises the raw line, detects recovered-clock rising edges and shifts
// polarity-corrected bits into the sync/data shift register.
module bit_deframer_bit_sampler
  import bit_deframer_pkg::*;
#(
  parameter int unsigned SYNC_W = DEF_SYNC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signal_i,
  input  logic              clk_rec_i,
  input  logic              pol_inv_i,
  output logic              bit_tick_o,
  output logic [SYNC_W-1:0] sr_o
);

  logic              sync1_q;
  logic              sync2_q;
  logic              rec_q;
  logic              tick_q;
  logic [SYNC_W-1:0] sr_q;
  logic              bit_tick_c;

  assign bit_tick_c = clk_rec_i & ~rec_q;

  // bit_tick_o lags the shift by one cycle so it always sees the updated sr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rec_q   <= 1'b0;
      tick_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      sync1_q <= signal_i;
      sync2_q <= sync1_q;
      rec_q   <= clk_rec_i;
      tick_q  <= bit_tick_c;
      if (bit_tick_c) begin
        sr_q <= {sr_q[SYNC_W-2:0], sync2_q ^ pol_inv_i};
      end
    end
  end

  assign bit_tick_o = tick_q;
  assign sr_o       = sr_q;

endmodule : bit_deframer_bit_sampler

// File: rtl/bit_deframer.sv
// Sync-word hunting frame deframer with flywheel lock and byte output.
// Optional BIT_DEFRAMER_POLARITY_EN: lock on the inverted sync word and invert the line.
module bit_deframer
  import bit_deframer_pkg::*;
#(
  parameter int unsigned       SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(DEF_SYNC_WORD),
  parameter int unsigned       FRAME_BYTES = 32,
  parameter int unsigned       MAX_MISS    = 3
) (
  input  logic           clk_300M,
  input  logic           rst_n,
  bit_deframer_if.master bus
);

  localparam int unsigned BIT_CNT_W  = clog2(SYNC_W);
  localparam int unsigned BYTE_CNT_W = clog2(FRAME_BYTES + 1);
  localparam int unsigned MISS_W     = 4;

  localparam logic [BIT_CNT_W-1:0]  LAST_DATA_BIT = BIT_CNT_W'(BYTE_W - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_SYNC_BIT = BIT_CNT_W'(SYNC_W - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE     = BYTE_CNT_W'(FRAME_BYTES - 1);
  localparam logic [MISS_W-1:0]     MISS_LIMIT    = MISS_W'(MAX_MISS);

  state_e                 state_q,      state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [BYTE_CNT_W-1:0]  byte_cnt_q,   byte_cnt_d;
  logic [MISS_W-1:0]      miss_q,       miss_d;
  logic                   locked_q,     locked_d;
  logic [BYTE_W-1:0]      byte_data_q,  byte_data_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   byte_first_q, byte_first_d;
  logic                   sync_err_q,   sync_err_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q,  frame_cnt_d;

  logic                   bit_tick_w;
  logic [SYNC_W-1:0]      sr_w;
  logic                   pol_inv_w;
  logic                   sync_hit_c;
  logic                   sync_inv_hit_c;
  logic [MISS_W-1:0]      miss_inc_c;

  bit_deframer_bit_sampler #(
    .SYNC_W (SYNC_W)
  ) u_bit_sampler (
    .clk        (clk_300M),
    .rst_n      (rst_n),
    .signal_i   (bus.signal),
    .clk_rec_i  (bus.clk_rec),
    .pol_inv_i  (pol_inv_w),
    .bit_tick_o (bit_tick_w),
    .sr_o       (sr_w)
  );

  assign sync_hit_c = (sr_w == SYNC_WORD);
  assign miss_inc_c = miss_q + MISS_W'(1);

`ifdef BIT_DEFRAMER_POLARITY_EN
  logic pol_inv_q, pol_inv_d;

  assign sync_inv_hit_c = (sr_w == ~SYNC_WORD);
  assign pol_inv_w      = pol_inv_q;

  always_ff @(posedge clk_300M or negedge rst_n) begin
    if (!rst_n) begin
      pol_inv_q <= 1'b0;
    end else begin
      pol_inv_q <= pol_inv_d;
    end
  end
`else
  assign sync_inv_hit_c = 1'b0;
  assign pol_inv_w      = 1'b0;
`endif

  // Next-state and output decode; everything advances only on a bit tick.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    byte_first_d = 1'b0;
    sync_err_d   = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef BIT_DEFRAMER_POLARITY_EN
    pol_inv_d    = pol_inv_q;
`endif

    if (bit_tick_w) begin
      case (state_q)
        ST_HUNT: begin
          if (sync_hit_c || sync_inv_hit_c) begin
            state_d    = ST_DATA;
            locked_d   = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miss_d     = '0;
`ifdef BIT_DEFRAMER_POLARITY_EN
            pol_inv_d  = sync_inv_hit_c;
`endif
          end
        end

        ST_DATA: begin
          if (bit_cnt_q == LAST_DATA_BIT) begin
            bit_cnt_d    = '0;
            byte_data_d  = sr_w[BYTE_W-1:0];
            byte_valid_d = 1'b1;
            byte_first_d = (byte_cnt_q == '0);
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = ST_CHECK;
            end else begin
              byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end

        ST_CHECK: begin
          if (bit_cnt_q == LAST_SYNC_BIT) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            if (sync_hit_c) begin
              miss_d  = '0;
              state_d = ST_DATA;
              if (frame_cnt_q != {FRAME_CNT_W{1'b1}}) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
              end
            end else begin
              sync_err_d = 1'b1;
              miss_d     = miss_inc_c;
              // Flywheel: keep the frame alignment until the miss budget runs out.
              if (miss_inc_c == MISS_LIMIT) begin
                locked_d = 1'b0;
                state_d  = ST_HUNT;
`ifdef BIT_DEFRAMER_POLARITY_EN
                pol_inv_d = 1'b0;
`endif
              end else begin
                state_d = ST_DATA;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_300M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_first_q <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_first_q <= byte_first_d;
      sync_err_q   <= sync_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_first = byte_first_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.pol_inv    = pol_inv_w;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule : bit_deframer

// File: tb/tb_bit_deframer.sv
// Scoreboard bench for bit_deframer: intended frame events are queued as the line
// is driven, and a monitor pops them as the DUT strobes bytes, sync errors and frame counts.
module tb_bit_deframer;

  localparam logic [15:0] SYNC = 16'hEB90;
  localparam int EV_BYTE  = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_FRAME = 2;
  localparam int SY_HUNT  = 0;
  localparam int SY_GOOD  = 1;
  localparam int SY_BAD   = 2;

  typedef struct {
    int         kind;
    logic [15:0] data;
    logic        first;
  } evt_t;

  logic clk_300M = 1'b0;
  logic rst_n    = 1'b0;

  bit_deframer_if bus ();

  bit_deframer dut (
    .clk_300M (clk_300M),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_300M = ~clk_300M;

  int unsigned n_checks   = 0;
  int unsigned n_pass     = 0;
  int          half       = 15;
  int unsigned exp_frames = 0;
  evt_t        exp_q[$];
  logic [7:0]  payload[32];
  logic [15:0] prev_fc = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
  endtask

  task automatic push_evt(input int kind, input logic [15:0] data, input logic first);
    evt_t e;
    e.kind  = kind;
    e.data  = data;
    e.first = first;
    exp_q.push_back(e);
  endtask

  task automatic take_evt(input int kind, input logic [15:0] data, input logic first);
    evt_t e;
    if (exp_q.size() == 0) begin
      check("unexpected event kind", 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    check("event kind", 32'(kind), 32'(e.kind));
    if (kind == e.kind && kind == EV_BYTE) begin
      check("byte_data", 32'(data), 32'(e.data));
      check("byte_first", 32'(first), 32'(e.first));
    end else if (kind == e.kind && kind == EV_FRAME) begin
      check("frame_cnt step", 32'(data), 32'(e.data));
    end
  endtask

  // One line bit: data changes with the falling recovered clock, sampled on the rise.
  task automatic send_bit(input logic b);
    bus.signal  = b;
    bus.clk_rec = 1'b0;
    repeat (half) @(negedge clk_300M);
    bus.clk_rec = 1'b1;
    repeat (half) @(negedge clk_300M);
  endtask

  task automatic send_byte(input logic [7:0] line, input bit exp_on,
                           input logic [7:0] want, input logic first);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && exp_on) push_evt(EV_BYTE, {8'h00, want}, first);
      send_bit(line[i]);
    end
  endtask

  task automatic send_sync(input logic [15:0] word, input int mode);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0 && mode == SY_GOOD) begin
        exp_frames++;
        push_evt(EV_FRAME, 16'(exp_frames), 1'b0);
      end else if (i == 0 && mode == SY_BAD) begin
        push_evt(EV_ERR, 16'h0, 1'b0);
      end
      send_bit(word[i]);
    end
  endtask

  task automatic send_frame(input bit invert, input bit exp_on);
    for (int j = 0; j < 32; j++) begin
      send_byte(invert ? ~payload[j] : payload[j], exp_on, payload[j], 1'(j == 0));
    end
  endtask

  task automatic rand_payload();
    for (int j = 0; j < 32; j++) payload[j] = 8'($urandom);
  endtask

  task automatic ramp_payload();
    for (int j = 0; j < 32; j++) payload[j] = 8'(j);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.byte_data, bus.byte_valid, bus.byte_first, bus.locked,
                     bus.sync_err, bus.pol_inv, bus.frame_cnt}), 32'h0);
  endtask

  // Monitor: every DUT-side event must match the oldest queued expectation.
  always @(negedge clk_300M) begin
    if (!rst_n) begin
      prev_fc = 16'h0;
    end else begin
      if (bus.byte_valid) take_evt(EV_BYTE, {8'h00, bus.byte_data}, bus.byte_first);
      if (bus.sync_err) take_evt(EV_ERR, 16'h0, 1'b0);
      if (bus.frame_cnt != prev_fc) begin
        take_evt(EV_FRAME, bus.frame_cnt, 1'b0);
        prev_fc = bus.frame_cnt;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time budget at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bad;
    bus.signal  = 1'b0;
    bus.clk_rec = 1'b0;

    // Reset and idle line
    repeat (4) @(negedge clk_300M);
    check_all_zero("outputs in reset");
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) begin
      send_bit(1'b0);
      check("idle locked", 32'(bus.locked), 32'h0);
    end
    check_all_zero("outputs after idle");

    // Lock on EB90 exactly at the 16th sync bit, ramp payload, closing sync
    for (int i = 15; i >= 1; i--) send_bit(SYNC[i]);
    check("locked before 16th sync bit", 32'(bus.locked), 32'h0);
    send_bit(SYNC[0]);
    check("locked after 16th sync bit", 32'(bus.locked), 32'h1);
    check("pol_inv on true match", 32'(bus.pol_inv), 32'h0);
    ramp_payload();
    send_frame(1'b0, 1'b1);
    send_sync(SYNC, SY_GOOD);
    check("frame_cnt after second sync", 32'(bus.frame_cnt), 32'h1);

    // Flywheel: isolated miss, miss reset by a good sync, then three in a row
    half = 5;
    rand_payload();
    send_frame(1'b0, 1'b1);
    bad = SYNC ^ (16'h1 << $urandom_range(15, 0));
    send_sync(bad, SY_BAD);
    check("locked after one bad sync", 32'(bus.locked), 32'h1);
    rand_payload();
    send_frame(1'b0, 1'b1);
    send_sync(SYNC, SY_GOOD);
    rand_payload();
    send_frame(1'b0, 1'b1);
    send_sync(16'hEB91, SY_BAD);
    rand_payload();
    send_frame(1'b0, 1'b1);
    bad = SYNC ^ (16'h1 << $urandom_range(15, 0));
    send_sync(bad, SY_BAD);
    check("locked after two bad syncs", 32'(bus.locked), 32'h1);
    rand_payload();
    send_frame(1'b0, 1'b1);
    send_sync(16'hEB91, SY_BAD);
    check("locked after third bad sync", 32'(bus.locked), 32'h0);
    send_sync(SYNC, SY_HUNT);
    check("relocked after good sync", 32'(bus.locked), 32'h1);
    rand_payload();
    send_frame(1'b0, 1'b1);
    send_sync(SYNC, SY_GOOD);
    check("frame_cnt after relock", 32'(bus.frame_cnt), 32'(exp_frames));

    // Sync pattern embedded in payload must not realign
    rand_payload();
    payload[5] = 8'hEB;
    payload[6] = 8'h90;
    send_frame(1'b0, 1'b1);
    send_sync(SYNC, SY_GOOD);

    // Reset in the middle of byte 10
    rand_payload();
    for (int j = 0; j < 10; j++) send_byte(payload[j], 1'b1, payload[j], 1'(j == 0));
    for (int i = 7; i >= 4; i--) send_bit(payload[10][i]);
    check("locked before mid-byte reset", 32'(bus.locked), 32'h1);
    check("pending events before reset", 32'(exp_q.size()), 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("outputs right after reset assert");
    exp_frames = 0;
    repeat (3) @(negedge clk_300M);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_sync(SYNC, SY_HUNT);
    check("relock after reset", 32'(bus.locked), 32'h1);
    rand_payload();
    send_frame(1'b0, 1'b1);
    send_sync(SYNC, SY_GOOD);
    check("frame_cnt restarts after reset", 32'(bus.frame_cnt), 32'h1);

    // Fully inverted stream
    rst_n = 1'b0;
    repeat (2) @(negedge clk_300M);
    exp_frames = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_sync(~SYNC, SY_HUNT);
    ramp_payload();
`ifdef BIT_DEFRAMER_POLARITY_EN
    check("inverted lock", 32'(bus.locked), 32'h1);
    check("pol_inv after inverted lock", 32'(bus.pol_inv), 32'h1);
    send_frame(1'b1, 1'b1);
    send_sync(~SYNC, SY_GOOD);
    check("frame_cnt on inverted stream", 32'(bus.frame_cnt), 32'h1);
`else
    send_frame(1'b1, 1'b0);
    check("inverted stream stays unlocked", 32'(bus.locked), 32'h0);
    check("pol_inv tied low", 32'(bus.pol_inv), 32'h0);
`endif

    repeat (20) @(negedge clk_300M);
    check("pending events at end", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bit_deframer
